// File: rtl/std_gray_codec.sv
// Pipelined multi-channel Gray/binary converter with valid/ready flow control.
// Decode spreads the prefix-XOR over STAGES register stages, MSB slice first;
// encode is done in stage 0 and rides the pipe so both modes share one latency.
// An optional step checker flags decode inputs that move by more than one bit.
module std_gray_codec #(
    parameter int DW     = 32,
    parameter int CH     = 1,
    parameter int STAGES = 2,
    parameter int CHECK  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [CH*DW-1:0] out_data,
    output logic [CH-1:0]    out_err,
    output logic [15:0]      err_cnt
);
    localparam int SL = (DW + STAGES - 1) / STAGES;

    logic [STAGES-1:0]            stg_v;
    logic [STAGES-1:0]            stg_mode;
    logic [STAGES-1:0]            load;
    logic [STAGES-1:0][CH*DW-1:0] stg_data;
    logic [STAGES-1:0][CH-1:0]    stg_err;
    logic [CH-1:0]                in_err;
    logic                         accept;

    // A stage may load when it is empty or everything below it advances, so bubbles collapse
    always_comb begin
        logic go;
        go   = out_ready;
        load = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            go      = go || !stg_v[s];
            load[s] = go;
        end
    end

    assign in_ready = load[0] && !rst;
    assign accept   = in_valid && in_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Bit slice resolved here; slices past bit 0 are empty and pass through
        localparam int HI    = DW - 1 - s * SL;
        localparam int LO    = (DW - (s + 1) * SL > 0) ? DW - (s + 1) * SL : 0;
        localparam bit HAS_C = (HI >= 0) && (HI < DW - 1);
        localparam int CI    = HAS_C ? HI + 1 : 0;

        logic             src_v;
        logic             src_mode;
        logic [CH*DW-1:0] src_data;
        logic [CH-1:0]    src_err;
        logic [CH*DW-1:0] data_d;
        logic [CH*DW-1:0] data_q;
        logic [CH-1:0]    err_q;
        logic             v_q;
        logic             mode_q;

        if (s == 0) begin : g_head
            assign src_v    = in_valid;
            assign src_mode = in_mode;
            assign src_data = in_data;
            assign src_err  = in_err;
        end else begin : g_body
            assign src_v    = stg_v[s-1];
            assign src_mode = stg_mode[s-1];
            assign src_data = stg_data[s-1];
            assign src_err  = stg_err[s-1];
        end

        // Resolve this slice from the already-binary bit just above it; encode words pass through
        always_comb begin
            logic c;
            c      = 1'b0;
            data_d = src_data;
            if (s == 0 && src_mode) begin
                for (int ch = 0; ch < CH; ch++)
                    data_d[ch*DW +: DW] = src_data[ch*DW +: DW] ^ (src_data[ch*DW +: DW] >> 1);
            end else if (!src_mode) begin
                for (int ch = 0; ch < CH; ch++) begin
                    c = HAS_C ? src_data[ch*DW + CI] : 1'b0;
                    for (int i = DW - 1; i >= 0; i--) begin
                        if (i <= HI && i >= LO) begin
                            c                  = c ^ src_data[ch*DW + i];
                            data_d[ch*DW + i]  = c;
                        end
                    end
                end
            end
        end

        // Stage register: valid follows every load, payload only moves with a real beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q    <= 1'b0;
                mode_q <= 1'b0;
                data_q <= '0;
                err_q  <= '0;
            end else if (load[s]) begin
                v_q <= src_v;
                if (src_v) begin
                    mode_q <= src_mode;
                    data_q <= data_d;
                    err_q  <= src_err;
                end
            end
        end

        assign stg_v[s]    = v_q;
        assign stg_mode[s] = mode_q;
        assign stg_data[s] = data_q;
        assign stg_err[s]  = err_q;
    end

    assign out_valid = stg_v[STAGES-1];
    assign out_mode  = stg_mode[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_err   = stg_err[STAGES-1];

    if (CHECK != 0) begin : g_chk
        logic [CH*DW-1:0] hist_q;
        logic             hist_vld_q;
        logic [15:0]      cnt_q;
        logic [15:0]      cnt_d;

        // More than one bit set in the step means the decode input was not a legal Gray move
        always_comb begin
            logic [DW-1:0] x;
            x      = '0;
            in_err = '0;
            for (int ch = 0; ch < CH; ch++) begin
                x          = in_data[ch*DW +: DW] ^ hist_q[ch*DW +: DW];
                in_err[ch] = !in_mode && hist_vld_q && ((x & (x - 1'b1)) != '0);
            end
        end

        // History tracks accepted decode beats only
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_q     <= '0;
                hist_vld_q <= 1'b0;
            end else if (accept && !in_mode) begin
                hist_q     <= in_data;
                hist_vld_q <= 1'b1;
            end
        end

        // Saturating count of output transfers carrying any step error
        always_comb begin
            cnt_d = cnt_q;
            if (out_valid && out_ready && (|out_err) && cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end

        // Error counter register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign err_cnt = cnt_q;
    end else begin : g_nochk
        assign in_err  = '0;
        assign err_cnt = '0;
    end

endmodule

// File: tb/tb_std_gray_codec.sv
// Directed bench for std_gray_codec: small 2-channel checked instance plus a
// 32-bit, 32-stage unchecked instance sharing clock and reset.
module tb_std_gray_codec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [7:0]  a_in_data, a_out_data;
    logic [1:0]  a_out_err;
    logic [15:0] a_err_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [31:0] b_in_data, b_out_data;
    logic [0:0]  b_out_err;
    logic [15:0] b_err_cnt;

    std_gray_codec #(.DW(4), .CH(2), .STAGES(2), .CHECK(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
        .out_data(a_out_data), .out_err(a_out_err), .err_cnt(a_err_cnt)
    );

    std_gray_codec #(.DW(32), .CH(1), .STAGES(32), .CHECK(0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
        .out_data(b_out_data), .out_err(b_out_err), .err_cnt(b_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference Gray decode: bin[i] = XOR of g[31:i]
    function automatic logic [31:0] px(input logic [31:0] g);
        logic [31:0] r;
        logic        acc;
        r   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc  = acc ^ g[i];
            r[i] = acc;
        end
        return r;
    endfunction

    // One isolated beat into instance A with out_ready=1 and an empty pipe
    task automatic beat(input string tag, input logic m, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic [1:0] exp_e);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
        #1 chk({tag, ".rdy"}, 32'(a_in_ready), 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(a_out_valid), 0);
        @(negedge clk);
        chk({tag, ".vld"},  32'(a_out_valid), 1);
        chk({tag, ".data"}, 32'(a_out_data), 32'(exp_d));
        chk({tag, ".mode"}, 32'(a_out_mode), 32'(m));
        chk({tag, ".err"},  32'(a_out_err),  32'(exp_e));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic stream_a(input int n, inout int k);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_mode = 1'b0;
            a_in_data  = k[0] ? 8'h03 : 8'h00;
            k++;
        end
        @(negedge clk); a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0]  bb_in  [4];
    logic [7:0]  bb_exp [4];
    logic        bb_m   [4];
    logic [31:0] bw     [40];
    logic [31:0] bexp   [40];
    logic        bm     [40];

    initial begin
        int tx, rx, k;
        logic [3:0] g4, r4;

        a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 32'(a_in_ready), 0);
        chk("rst.out_valid", 32'(a_out_valid), 0);
        chk("rst.out_data", 32'(a_out_data), 0);
        chk("rst.err_cnt", 32'(a_err_cnt), 0);
        chk("rst.b_out_valid", 32'(b_out_valid), 0);
        rst = 1'b0;
        #1 chk("rel.in_ready", 32'(a_in_ready), 1);

        // 1: decode 0110 -> 0100, 1000 -> 1111
        beat("t1", 1'b0, 8'h86, 8'hF4, 2'b00);

        // 2: encode 1011 -> 1110, 0000 -> 0000
        beat("t2", 1'b1, 8'h0B, 8'h0E, 2'b00);

        // 2b: alternating decode/encode back to back
        bb_in  = '{8'h87, 8'h35, 8'h95, 8'hF8};
        bb_exp = '{8'hF5, 8'h27, 8'hE6, 8'h8C};
        bb_m   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 1) chk("t2b.lat1", 32'(a_out_valid), 0);
            if (j >= 2) begin
                chk("t2b.vld",  32'(a_out_valid), 1);
                chk("t2b.data", 32'(a_out_data), 32'(bb_exp[j-2]));
                chk("t2b.mode", 32'(a_out_mode), 32'(bb_m[j-2]));
                chk("t2b.err",  32'(a_out_err), 0);
            end
            if (j < 4) begin
                a_in_valid = 1'b1; a_in_mode = bb_m[j]; a_in_data = bb_in[j];
            end else begin
                a_in_valid = 1'b0;
            end
        end

        // 3: Gray count 0..15 on both channels with out_ready toggling
        do_reset();
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 200 && rx < 16; cyc++) begin
            @(negedge clk);
            a_out_ready = (cyc % 2 == 0);
            g4 = 4'(tx ^ (tx >> 1));
            a_in_valid = (tx < 16); a_in_mode = 1'b0; a_in_data = {g4, g4};
            #1;
            if (a_out_valid) begin
                r4 = rx[3:0];
                chk("t3.data", 32'(a_out_data), 32'({r4, r4}));
                chk("t3.err",  32'(a_out_err), 0);
                if (a_out_ready) rx++;
            end
            if (a_in_valid && a_in_ready) tx++;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("t3.count", 32'(rx), 16);
        @(negedge clk);
        chk("t3.err_cnt", 32'(a_err_cnt), 0);

        // 4: 2-bit step flagged; encode leaves history alone
        beat("t4a", 1'b0, 8'h00, 8'h00, 2'b00);
        beat("t4b", 1'b0, 8'h03, 8'h02, 2'b01);
        @(negedge clk);
        chk("t4.err_cnt1", 32'(a_err_cnt), 1);
        beat("t4c", 1'b1, 8'h05, 8'h07, 2'b00);
        beat("t4d", 1'b0, 8'h01, 8'h01, 2'b00);
        @(negedge clk);
        chk("t4.err_cnt2", 32'(a_err_cnt), 1);

        // 5: fill with out_ready=0, then asynchronous reset mid-stream
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'h13;
        @(negedge clk);
        a_in_data = 8'h03;
        @(negedge clk);
        #1;
        chk("t5.full_vld", 32'(a_out_valid), 1);
        chk("t5.full_rdy", 32'(a_in_ready), 0);
        chk("t5.full_data", 32'(a_out_data), 'h12);
        @(negedge clk);
        chk("t5.hold_data", 32'(a_out_data), 'h12);
        chk("t5.hold_cnt", 32'(a_err_cnt), 1);
        #2 rst = 1'b1; a_in_valid = 1'b0;
        #1;
        chk("t5.rst_vld", 32'(a_out_valid), 0);
        chk("t5.rst_data", 32'(a_out_data), 0);
        chk("t5.rst_cnt", 32'(a_err_cnt), 0);
        chk("t5.rst_rdy", 32'(a_in_ready), 0);
        @(negedge clk);
        rst = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("t5.flushed", 32'(a_out_valid), 0);
        beat("t5.first", 1'b0, 8'hFF, 8'hAA, 2'b00);

        // 6a: 32-bit, 32-stage instance, continuous traffic
        for (int j = 0; j < 40; j++) begin
            bw[j]   = (j == 0) ? 32'h8000_0000 : $urandom;
            bm[j]   = (j % 7 == 3);
            bexp[j] = bm[j] ? (bw[j] ^ (bw[j] >> 1)) : px(bw[j]);
        end
        chk("t6.ref_hand", px(32'h8000_0000), 'hFFFF_FFFF);
        for (int j = 0; j < 72; j++) begin
            @(negedge clk);
            if (j == 31) chk("t6.lat31", 32'(b_out_valid), 0);
            if (j >= 32) begin
                chk("t6.vld",  32'(b_out_valid), 1);
                chk("t6.data", b_out_data, bexp[j-32]);
                chk("t6.mode", 32'(b_out_mode), 32'(bm[j-32]));
                chk("t6.err",  32'(b_out_err), 0);
            end
            if (j < 40) begin
                b_in_valid = 1'b1; b_in_mode = bm[j]; b_in_data = bw[j];
            end else begin
                b_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("t6.b_err_cnt", 32'(b_err_cnt), 0);

        // 6b: error counter saturation on the checked instance
        do_reset();
        k = 0;
        stream_a(100, k);
        chk("t6.cnt99", 32'(a_err_cnt), 99);
        stream_a(65435, k);
        chk("t6.cntFFFE", 32'(a_err_cnt), 'hFFFE);
        stream_a(5, k);
        chk("t6.cntSat", 32'(a_err_cnt), 'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
